// File: rtl/store_merge_buffer.sv
// Single-line write-combining buffer: folds LC-3b byte/word stores into one
//   16-byte line and writes it to L2 as a single masked 128-bit line write.
// Latency: hit/empty store acked same cycle; a drain takes 1 cycle to raise
//   l2_write plus the L2 response time.
// Backpressure: st_ack and flush_done stay low while a line drain is pending;
//   the L2 side holds l2_write until l2_resp.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   st_req/st_ack        store handshake; st_addr, st_wdata, st_be qualify it
//   flush_req/flush_done drain-everything handshake
//   l2_write/l2_resp     line write handshake; l2_address, l2_wdata, l2_mask
//   buf_valid, buf_tag   buffer status (tag = st_addr[15:4] of the line)
module store_merge_buffer #(
  parameter bit AUTO_DRAIN_FULL = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         st_req,
  input  logic [15:0]  st_addr,
  input  logic [15:0]  st_wdata,
  input  logic [1:0]   st_be,
  output logic         st_ack,
  input  logic         flush_req,
  output logic         flush_done,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic [15:0]  l2_mask,
  input  logic         l2_resp,
  output logic         buf_valid,
  output logic [11:0]  buf_tag
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [11:0]  tag_q, tag_d;
  logic [15:0]  mask_q, mask_d;
  logic [127:0] data_q, data_d;

  // Widen a per-byte mask to a per-bit mask over the 128-bit line.
  function automatic logic [127:0] expand_mask(input logic [15:0] m);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Store decode: byte mask and the store data placed on its line lanes.
  // Odd addresses are always byte stores whose data sits in the high half.
  // ------------------------------------------------------------------
  logic [3:0]   st_off;
  logic [15:0]  st_mask;
  logic [127:0] st_line;
  logic [127:0] st_bits;
  logic [127:0] merged_data;
  logic [15:0]  merged_mask;
  logic         tag_hit;

  assign st_off = st_addr[3:0];

  always_comb begin
    st_mask = '0;
    st_line = '0;
    if (st_off[0]) begin
      st_mask[st_off]              = 1'b1;
      st_line[{st_off, 3'b000} +: 8] = st_wdata[15:8];
    end else begin
      if (st_be[0]) begin
        st_mask[st_off]                = 1'b1;
        st_line[{st_off, 3'b000} +: 8] = st_wdata[7:0];
      end
      if (st_be[1]) begin
        // Even offset, so offset+1 is just the low bit set (no carry).
        st_mask[{st_off[3:1], 1'b1}]                = 1'b1;
        st_line[{st_off[3:1], 1'b1, 3'b000} +: 8]   = st_wdata[15:8];
      end
    end
  end

  assign st_bits     = expand_mask(st_mask);
  // New bytes overwrite old ones: the later store wins.
  assign merged_data = (data_q & ~st_bits) | (st_line & st_bits);
  assign merged_mask = mask_q | st_mask;
  assign tag_hit     = (tag_q == st_addr[15:4]);

  // ------------------------------------------------------------------
  // Next-state and handshake outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    mask_d     = mask_q;
    data_d     = data_q;
    st_ack     = 1'b0;
    flush_done = 1'b0;
    l2_write   = 1'b0;

    case (state_q)
      S_EMPTY: begin
        // Flush wins over a simultaneous store; the store is taken next cycle.
        if (flush_req) begin
          flush_done = 1'b1;
        end else if (st_req) begin
          st_ack = 1'b1;
          // A zero-mask store is acknowledged but allocates nothing.
          if (|st_mask) begin
            tag_d   = st_addr[15:4];
            mask_d  = st_mask;
            data_d  = st_line;
            state_d = S_VALID;
          end
        end
      end

      S_VALID: begin
        // A store to another line must wait for the current line to leave.
        if (flush_req || (st_req && !tag_hit)) begin
          state_d = S_DRAIN;
        end else if (st_req) begin
          st_ack = 1'b1;
          mask_d = merged_mask;
          data_d = merged_data;
          if (AUTO_DRAIN_FULL && (merged_mask == 16'hFFFF)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        l2_write = 1'b1;
        if (l2_resp) begin
          mask_d  = '0;
          state_d = S_EMPTY;
        end
      end

      default: begin
        state_d = S_EMPTY;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      tag_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  // Line outputs come straight from the buffer so they are stable for the
  // whole drain; unwritten lanes are forced to zero.
  assign l2_address = {tag_q, 4'h0};
  assign l2_mask    = mask_q;
  assign l2_wdata   = data_q & expand_mask(mask_q);
  assign buf_valid  = (state_q != S_EMPTY);
  assign buf_tag    = tag_q;

endmodule

// File: tb/tb_store_merge_buffer.sv
// Scoreboarded bench for store_merge_buffer: a transaction-level line model
//   predicts every L2 line write; a monitor checks each one as L2 accepts it.
// Directed scenarios cover handshake latencies, reset and boundary cases.
module tb_store_merge_buffer;

  localparam bit AUTO = 1'b1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         st_req;
  logic [15:0]  st_addr;
  logic [15:0]  st_wdata;
  logic [1:0]   st_be;
  logic         st_ack;
  logic         flush_req;
  logic         flush_done;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [15:0]  l2_mask;
  logic         l2_resp;
  logic         buf_valid;
  logic [11:0]  buf_tag;

  always #5 clk = ~clk;

  store_merge_buffer #(.AUTO_DRAIN_FULL(AUTO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .st_ack     (st_ack),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_mask    (l2_mask),
    .l2_resp    (l2_resp),
    .buf_valid  (buf_valid),
    .buf_tag    (buf_tag)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: one line of 16 bytes, a mask, a tag, a valid flag.
  // ------------------------------------------------------------------
  typedef struct {
    logic [15:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
  } line_t;

  line_t       exp_q[$];
  logic [7:0]  m_data[16];
  logic [15:0] m_mask  = '0;
  logic [11:0] m_tag   = '0;
  bit          m_valid = 1'b0;

  function automatic void push_line();
    line_t l;
    l.addr = {m_tag, 4'h0};
    l.mask = m_mask;
    l.data = '0;
    for (int i = 0; i < 16; i++)
      if (m_mask[i]) l.data[8*i +: 8] = m_data[i];
    exp_q.push_back(l);
    m_valid = 1'b0;
    m_mask  = '0;
  endfunction

  function automatic void model_store(input logic [15:0] a, input logic [15:0] d,
                                      input logic [1:0] be);
    logic [15:0] nm;
    logic [7:0]  nv[16];
    int          off;
    nm  = '0;
    off = int'(a[3:0]);
    for (int i = 0; i < 16; i++) nv[i] = 8'h00;
    if (a[0]) begin
      nm[off] = 1'b1; nv[off] = d[15:8];
    end else begin
      if (be[0]) begin nm[off] = 1'b1;   nv[off] = d[7:0];    end
      if (be[1]) begin nm[off+1] = 1'b1; nv[off+1] = d[15:8]; end
    end
    // Any store to a different line evicts the held line first.
    if (m_valid && (m_tag != a[15:4])) push_line();
    if (nm == 16'h0000) return;
    if (!m_valid) begin
      m_valid = 1'b1;
      m_tag   = a[15:4];
    end
    for (int i = 0; i < 16; i++)
      if (nm[i]) begin m_data[i] = nv[i]; m_mask[i] = 1'b1; end
    if (AUTO && (m_mask == 16'hFFFF)) push_line();
  endfunction

  function automatic void model_flush();
    if (m_valid) push_line();
  endfunction

  // ------------------------------------------------------------------
  // L2 responder: answers each line write resp_gap cycles after it starts.
  // ------------------------------------------------------------------
  int resp_gap = 2;
  int wcnt     = 0;

  initial begin
    l2_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!l2_write || l2_resp) begin
        wcnt    = 0;
        l2_resp = 1'b0;
      end else begin
        wcnt++;
        if (wcnt > resp_gap) l2_resp = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Monitor: compares each accepted line write against the scoreboard.
  // ------------------------------------------------------------------
  int           resp_cyc = -10;
  logic [127:0] last_wdata = '0;

  initial begin : monitor
    line_t e;
    forever begin
      @(negedge clk);
      if (reset_n && l2_write && l2_resp) begin
        resp_cyc   = cyc;
        last_wdata = l2_wdata;
        if (exp_q.size() == 0) begin
          chk("unexpected_line_write", {112'h0, l2_address}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("line_addr", {112'h0, l2_address}, {112'h0, e.addr});
          chk("line_mask", {112'h0, l2_mask}, {112'h0, e.mask});
          chk("line_data", l2_wdata, e.data);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus tasks (entered and left at posedge + 1)
  // ------------------------------------------------------------------
  int ack_cyc  = 0;
  int done_cyc = 0;

  task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, output int waited);
    model_store(a, d, be);
    st_addr  = a;
    st_wdata = d;
    st_be    = be;
    st_req   = 1'b1;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      if (st_ack) break;
      waited++;
      if (waited > 200) break;
    end
    chk("st_ack_timeout", {127'h0, (waited <= 200)}, 128'h1);
    ack_cyc = cyc;
    @(posedge clk); #1;
    st_req = 1'b0;
  endtask

  task automatic do_flush(output int waited);
    model_flush();
    flush_req = 1'b1;
    waited    = 0;
    while (1) begin
      @(negedge clk);
      if (flush_done) break;
      waited++;
      if (waited > 400) break;
    end
    chk("flush_done_timeout", {127'h0, (waited <= 400)}, 128'h1);
    done_cyc = cyc;
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || l2_write) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle_timeout"}, {127'h0, (n < 500)}, 128'h1);
  endtask

  task automatic check_state(input string name);
    if (!l2_write) begin
      chk({name, "_buf_valid"}, {127'h0, buf_valid}, {127'h0, m_valid});
      chk({name, "_mask"}, {112'h0, l2_mask}, {112'h0, m_mask});
      if (m_valid) chk({name, "_tag"}, {116'h0, buf_tag}, {116'h0, m_tag});
    end
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin : stim
    int w;
    logic [15:0] a;
    reset_n   = 1'b0;
    st_req    = 1'b0;
    st_addr   = '0;
    st_wdata  = '0;
    st_be     = '0;
    flush_req = 1'b0;
    for (int i = 0; i < 16; i++) m_data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_ack",     {127'h0, st_ack},     128'h0);
    chk("rst_flush_done", {127'h0, flush_done}, 128'h0);
    chk("rst_l2_write",   {127'h0, l2_write},   128'h0);
    chk("rst_l2_address", {112'h0, l2_address}, 128'h0);
    chk("rst_l2_wdata",   l2_wdata,             128'h0);
    chk("rst_l2_mask",    {112'h0, l2_mask},    128'h0);
    chk("rst_buf_valid",  {127'h0, buf_valid},  128'h0);
    chk("rst_buf_tag",    {116'h0, buf_tag},    128'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Flush with nothing buffered completes in the same cycle.
    do_flush(w);
    chk("empty_flush_latency", w, 0);

    // Word store after reset.
    do_store(16'h2002, 16'h1234, 2'b11, w);
    chk("s1_ack_latency", w, 0);
    chk("s1_buf_valid", {127'h0, buf_valid}, 128'h1);
    chk("s1_buf_tag",   {116'h0, buf_tag},   128'h200);
    chk("s1_mask",      {112'h0, l2_mask},   128'h000C);

    // Odd byte store merges in; be is ignored at odd addresses.
    do_store(16'h2005, 16'hAB00, 2'b00, w);
    chk("s2_ack_latency", w, 0);
    chk("s2_mask", {112'h0, l2_mask}, 128'h002C);
    resp_gap = 3;
    do_flush(w);
    chk("s2_flush_after_resp", done_cyc, resp_cyc + 1);
    chk("s2_line_data", last_wdata, 128'h0000_0000_0000_0000_0000_AB00_1234_0000);
    chk("s2_buf_valid", {127'h0, buf_valid}, 128'h0);

    // Line conflict: the second store waits for the first line to drain.
    resp_gap = 2;
    do_store(16'h2000, 16'h5566, 2'b11, w);
    do_store(16'h3000, 16'h7788, 2'b11, w);
    chk("s3_ack_held", {127'h0, (w > 0)}, 128'h1);
    chk("s3_ack_after_resp", ack_cyc, resp_cyc + 1);
    chk("s3_buf_tag", {116'h0, buf_tag}, 128'h300);
    chk("s3_mask",    {112'h0, l2_mask}, 128'h0003);
    do_flush(w);
    wait_idle("s3");

    // Full line drains on its own after the eighth word.
    resp_gap = 1;
    for (int i = 0; i < 8; i++) begin
      a = 16'h4000 + 16'(2 * i);
      do_store(a, 16'($urandom), 2'b11, w);
    end
    @(negedge clk);
    chk("s4_auto_l2_write", {127'h0, l2_write}, 128'h1);
    chk("s4_auto_mask",     {112'h0, l2_mask},  128'hFFFF);
    wait_idle("s4");

    // Zero-mask store into an empty buffer.
    do_store(16'h5000, 16'hDEAD, 2'b00, w);
    chk("s5_ack_latency", w, 0);
    chk("s5_buf_valid", {127'h0, buf_valid}, 128'h0);
    repeat (3) @(negedge clk);
    chk("s5_no_l2_write", {127'h0, l2_write}, 128'h0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a drain.
    resp_gap = 1000;
    do_store(16'h6010, 16'hCAFE, 2'b11, w);
    model_flush();
    flush_req = 1'b1;
    w = 0;
    while (!l2_write && w < 20) begin @(negedge clk); w++; end
    chk("s6_drain_started", {127'h0, l2_write}, 128'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_rst_l2_write",  {127'h0, l2_write},  128'h0);
    chk("s6_rst_buf_valid", {127'h0, buf_valid}, 128'h0);
    chk("s6_rst_mask",      {112'h0, l2_mask},   128'h0);
    flush_req = 1'b0;
    exp_q.delete();
    m_valid = 1'b0;
    m_mask  = '0;
    m_tag   = '0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    resp_gap = 2;
    @(posedge clk); #1;
    do_store(16'h6000, 16'h0102, 2'b11, w);
    chk("s6_post_rst_ack", w, 0);
    chk("s6_post_rst_tag", {116'h0, buf_tag}, 128'h600);
    do_flush(w);
    wait_idle("s6");

    // Random mix of stores over two lines, with occasional flushes.
    for (int n = 0; n < 80; n++) begin
      resp_gap = int'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) begin
        do_flush(w);
      end else begin
        a = {12'h700 + 12'($urandom_range(0, 1)), 4'($urandom)};
        do_store(a, 16'($urandom), 2'($urandom), w);
      end
      check_state("rnd1");
    end

    // Random word stores to one line, so full-line drains happen often.
    for (int n = 0; n < 40; n++) begin
      resp_gap = int'($urandom_range(0, 3));
      a = {12'h710, 3'($urandom), 1'b0};
      do_store(a, 16'($urandom), 2'b11, w);
      check_state("rnd2");
    end

    do_flush(w);
    wait_idle("final");
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_buf_valid", {127'h0, buf_valid}, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_merge_buffer.md
# store_merge_buffer

Single-line write-combining buffer between the LC-3b data-side store port and the line-wide (128-bit) write port of the L2/physical memory. It accepts byte and word stores, turns each into a 16-bit per-byte line mask, merges consecutive stores to the same 16-byte line, and drains the merged line as one masked line write. Drains happen on a line conflict, an explicit flush, or a full mask.

## Interface
- AUTO_DRAIN_FULL, 1, when 1 the buffer drains as soon as its mask reaches 16'hFFFF.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- st_req  in  1  store request; held until st_ack.
- st_addr  in  16  store byte address.
- st_wdata  in  16  store data, LC-3b layout (byte stores replicated in both halves).
- st_be  in  2  byte enables, bit0 = low byte, bit1 = high byte.
- st_ack  out  1  store accepted this cycle (combinational).
- flush_req  in  1  drain request; held until flush_done.
- flush_done  out  1  buffer empty and flush complete this cycle (combinational).
- l2_write  out  1  line write request; held until l2_resp.
- l2_address  out  16  line address {tag, 4'h0}.
- l2_wdata  out  128  line data; byte i = l2_wdata[8i+7:8i].
- l2_mask  out  16  byte i written when bit i = 1.
- l2_resp  in  1  line write complete.
- buf_valid  out  1  buffer holds at least one valid byte.
- buf_tag  out  12  tag of the buffered line, st_addr[15:4].

## Operation
- Store mask and data, with offset = st_addr[3:0]:
  - Even offset: st_be[0] writes byte offset from st_wdata[7:0]; st_be[1] writes byte offset+1 from st_wdata[15:8].
  - Odd offset: writes byte offset from st_wdata[15:8] only; st_be is ignored.
  - Even offset with st_be = 00: mask is zero; the store is acked with no state change.
- States:
  - EMPTY:
    - flush_req → flush_done = 1; st_ack = 0 (flush has priority).
    - Otherwise st_req → st_ack = 1. A nonzero mask loads tag, mask and data bytes and moves to VALID.
  - VALID, no flush_req:
    - st_req with tag match → st_ack = 1. Mask is ORed in and the masked bytes are overwritten (a later store wins).
    - If AUTO_DRAIN_FULL and the new mask = 16'hFFFF → DRAIN.
  - VALID, tag mismatch or flush_req: st_ack = 0 → DRAIN.
  - DRAIN:
    - l2_write = 1; l2_address, l2_wdata and l2_mask are stable from the buffer.
    - st_ack = 0 and flush_done = 0.
    - l2_resp → clear mask and buf_valid, go to EMPTY.
- Byte lanes of l2_wdata whose mask bit is 0 are driven 0.
- buf_valid = 1 in VALID and DRAIN. buf_tag holds its value until the next allocation.
- Stores are never reordered and never dropped once acked.

## Timing
- Reset values: st_ack 0, flush_done 0, l2_write 0, l2_address 16'h0000, l2_wdata 0, l2_mask 16'h0000, buf_valid 0, buf_tag 0; state EMPTY.
- Reset mid-DRAIN drops l2_write immediately (asynchronous) and discards buffered data. This is intended behaviour.
- Latencies:
  - Hit or EMPTY store: ack in the same cycle, state updated at that edge.
  - Conflicting store: detected in cycle 0, l2_write from cycle 1, l2_resp in cycle k, st_ack in cycle k+1.
  - Flush with data: flush_done in the cycle after l2_resp. Flush when empty: flush_done in the same cycle.
  - Full-mask auto-drain: l2_write asserted in the cycle after the completing ack.
- l2_resp outside DRAIN is ignored.
- st_req and flush_req held across DRAIN are serviced in EMPTY. Flush is served first; a still-held store is acked the next cycle.

## Test plan
- Store word after reset: st_addr 0x2002, wdata 0x1234, be 11 → st_ack the same cycle; next cycle buf_valid 1, buf_tag 0x200, mask 0x000C.
- Flush a merged line:
  - Stimulus: continuing from the previous scenario, odd byte store to 0x2005 with wdata 0xAB00, then flush_req; l2_resp 3 cycles after l2_write.
  - Response: l2_address 0x2000, l2_mask 0x002C; bytes 2, 3, 5 = 0x34, 0x12, 0xAB; all other bytes 0; flush_done 1 cycle after l2_resp; buf_valid 0.
- Line conflict:
  - Stimulus: buffer holds tag 0x200; store to 0x3000 with be 11.
  - Response: st_ack low until l2_resp; ack exactly 1 cycle after l2_resp; new buf_tag 0x300, mask 0x0003.
- Full line: 8 word stores to 0x4000..0x400E → l2_write in the cycle after the 8th ack, l2_mask 0xFFFF, without any flush.
- Empty-mask store: empty buffer, even store to 0x5000 with be 00 → st_ack 1, buf_valid stays 0, no l2_write.
- Reset during drain: reset_n low while l2_write = 1 → l2_write, buf_valid and l2_mask are 0 in the same cycle. After release, a store to 0x6000 is acked in EMPTY.
